ysyx_22050612_idex_stage: RTL and testbench

- Single-entry ID/EX pipeline register sitting directly upstream of the 64-bit ALU.
- Accepts decoded instructions from the decoder over a valid/ready handshake.
- Selects ALU operands: rs1 or PC for A; rs2 or immediate for B.
- Forwards the ALU's own result back into the next instruction's operands when there is a back-to-back RAW dependency.
- Drives the registered mode/A/B that the ALU consumes.

---
 rtl/ysyx_22050612_idex_stage.sv | 115 +++++++++++
 tb/tb_ysyx_22050612_idex_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_idex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: operand select, single-hop result forwarding.
// Optional performance counters are enabled with `define YSYX_22050612_IDEX_PERF_EN.
module ysyx_22050612_idex_stage #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned MODE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MODE_W-1:0] in_alu_mode,
   input  logic              in_src1_sel,
   input  logic              in_src2_sel,
   input  logic [4:0]        in_rs1_idx,
   input  logic [4:0]        in_rs2_idx,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [4:0]        in_rd,
   input  logic              in_rd_wen,
   input  logic [XLEN-1:0]   fwd_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MODE_W-1:0] alu_mode,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [4:0]        out_rd,
   output logic              out_rd_wen
`ifdef YSYX_22050612_IDEX_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_fwd_cnt
`endif
);

   localparam int unsigned REG_IDX_W = 5;

   logic                 r_valid;
   logic [MODE_W-1:0]    r_mode;
   logic [XLEN-1:0]      r_a;
   logic [XLEN-1:0]      r_b;
   logic [REG_IDX_W-1:0] r_rd;
   logic                 r_rd_wen;

   logic                 w_accept;
   logic                 w_leaving;
   logic                 w_fwd1;
   logic                 w_fwd2;
   logic [XLEN-1:0]      w_a;
   logic [XLEN-1:0]      w_b;

   // The held entry's result is on fwd_result only while it is being handed to the ALU stage.
   assign w_leaving = r_valid && out_ready;
   assign w_fwd1    = w_leaving && r_rd_wen && (r_rd != REG_IDX_W'(0)) && (r_rd == in_rs1_idx);
   assign w_fwd2    = w_leaving && r_rd_wen && (r_rd != REG_IDX_W'(0)) && (r_rd == in_rs2_idx);

   assign in_ready  = !flush && (!r_valid || out_ready);
   assign w_accept  = in_valid && in_ready;

   assign w_a = in_src1_sel ? in_pc  : (w_fwd1 ? fwd_result : in_rs1_data);
   assign w_b = in_src2_sel ? in_imm : (w_fwd2 ? fwd_result : in_rs2_data);

   // Pipeline register: data only moves on accept, so drain and stall keep it bit-stable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_mode   <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_rd     <= '0;
         r_rd_wen <= 1'b0;
      end else if (w_accept) begin
         r_valid  <= 1'b1;
         r_mode   <= in_alu_mode;
         r_a      <= w_a;
         r_b      <= w_b;
         r_rd     <= in_rd;
         r_rd_wen <= in_rd_wen;
      end else if (flush || w_leaving) begin
         r_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_valid;
   assign alu_mode   = r_mode;
   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign out_rd     = r_rd;
   assign out_rd_wen = r_rd_wen;

`ifdef YSYX_22050612_IDEX_PERF_EN
   logic        w_fwd_used;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;

   assign w_fwd_used = w_accept && ((!in_src1_sel && w_fwd1) || (!in_src2_sel && w_fwd2));

   // Free-running wrap-around event counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (r_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_fwd_used)            r_fwd_cnt   <= r_fwd_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
   assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_ysyx_22050612_idex_stage.sv
// Self-checking bench for ysyx_22050612_idex_stage; an adder stands in for the ALU on fwd_result.
module tb_ysyx_22050612_idex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_alu_mode;
   logic        in_src1_sel, in_src2_sel;
   logic [4:0]  in_rs1_idx, in_rs2_idx;
   logic [63:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic [63:0] fwd_result;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  alu_mode;
   logic [63:0] alu_a, alu_b;
   logic [4:0]  out_rd;
   logic        out_rd_wen;
`ifdef YSYX_22050612_IDEX_PERF_EN
   logic [31:0] perf_stall_cnt, perf_fwd_cnt;
   int unsigned m_stall, m_fwdc;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference state: what the stage should be holding
   logic        m_valid;
   logic [7:0]  m_mode;
   logic [63:0] m_a, m_b;
   logic [4:0]  m_rd;
   logic        m_wen;

   always #5 clk = ~clk;

   assign fwd_result = alu_a + alu_b;

   ysyx_22050612_idex_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_mode(in_alu_mode), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
      .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .fwd_result(fwd_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
      .out_rd(out_rd), .out_rd_wen(out_rd_wen)
`ifdef YSYX_22050612_IDEX_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
   );

   function automatic logic exp_ready();
      return !flush && (!m_valid || out_ready);
   endfunction

   // Advance one clock; the reference follows the stage rules using pre-edge inputs.
   task automatic tick();
      logic        acc, f1, f2, stall;
      logic [63:0] fr, na, nb;
      acc   = in_valid && exp_ready();
      fr    = m_a + m_b;
      f1    = m_valid && out_ready && m_wen && (m_rd != 5'd0) && (m_rd == in_rs1_idx);
      f2    = m_valid && out_ready && m_wen && (m_rd != 5'd0) && (m_rd == in_rs2_idx);
      na    = in_src1_sel ? in_pc  : (f1 ? fr : in_rs1_data);
      nb    = in_src2_sel ? in_imm : (f2 ? fr : in_rs2_data);
      stall = m_valid && !out_ready;
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1'b0; m_mode = '0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0;
`ifdef YSYX_22050612_IDEX_PERF_EN
         m_stall = 0; m_fwdc = 0;
`endif
      end else begin
`ifdef YSYX_22050612_IDEX_PERF_EN
         if (stall) m_stall = m_stall + 1;
         if (acc && ((!in_src1_sel && f1) || (!in_src2_sel && f2))) m_fwdc = m_fwdc + 1;
`endif
         if (acc) begin
            m_valid = 1'b1; m_mode = in_alu_mode; m_a = na; m_b = nb;
            m_rd = in_rd; m_wen = in_rd_wen;
         end else if (m_valid && (out_ready || flush)) begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic set_instr(input logic [7:0] mode, input logic s1, input logic s2,
                            input logic [4:0] r1, input logic [4:0] r2,
                            input logic [63:0] d1, input logic [63:0] d2,
                            input logic [63:0] pc, input logic [63:0] imm,
                            input logic [4:0] rd, input logic wen);
      in_valid = 1'b1; in_alu_mode = mode; in_src1_sel = s1; in_src2_sel = s2;
      in_rs1_idx = r1; in_rs2_idx = r2; in_rs1_data = d1; in_rs2_data = d2;
      in_pc = pc; in_imm = imm; in_rd = rd; in_rd_wen = wen;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
      set_instr(8'h5A, 1'b0, 1'b0, 5'd1, 5'd2, 64'h11, 64'h22, 64'h33, 64'h44, 5'd9, 1'b1);
      tick(); tick();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0d exp=0", out_valid); else n_pass++;
      n_checks++; if (alu_mode !== 8'h0) $display("FAIL reset_mode got=%h exp=0", alu_mode); else n_pass++;
      n_checks++; if (alu_a !== 64'h0) $display("FAIL reset_a got=%h exp=0", alu_a); else n_pass++;
      n_checks++; if (alu_b !== 64'h0) $display("FAIL reset_b got=%h exp=0", alu_b); else n_pass++;
      n_checks++; if (out_rd !== 5'd0 || out_rd_wen !== 1'b0)
         $display("FAIL reset_rd got=%0d/%0d exp=0/0", out_rd, out_rd_wen); else n_pass++;
      rst_n = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0d exp=1", in_ready); else n_pass++;
      tick();
      n_checks++; if (out_valid !== 1'b1 || alu_a !== 64'h11 || alu_mode !== 8'h5A)
         $display("FAIL reset_first_accept got=%0d/%h/%h exp=1/11/5a", out_valid, alu_a, alu_mode); else n_pass++;
   endtask

   task automatic test_basic_accept();
      out_ready = 1'b1;
      set_instr(8'h0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd5, 64'd7, 64'h100, 64'h200, 5'd4, 1'b0);
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%0d exp=1", out_valid); else n_pass++;
      n_checks++; if (alu_a !== 64'd5 || alu_b !== 64'd7)
         $display("FAIL basic_operands got=%0d/%0d exp=5/7", alu_a, alu_b); else n_pass++;
   endtask

   task automatic test_operand_select();
      set_instr(8'h3, 1'b1, 1'b1, 5'd0, 5'd0, 64'd1, 64'd2, 64'h80000000, 64'hFFFFFFFFFFFFFFFC, 5'd6, 1'b1);
      tick();
      n_checks++; if (alu_a !== 64'h80000000) $display("FAIL opsel_a got=%h exp=80000000", alu_a); else n_pass++;
      n_checks++; if (alu_b !== 64'hFFFFFFFFFFFFFFFC) $display("FAIL opsel_b got=%h exp=fffffffffffffffc", alu_b); else n_pass++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      set_instr(8'h0, 1'b1, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0, 64'd10, 64'd20, 5'd3, 1'b1);
      tick();
      set_instr(8'h0, 1'b0, 1'b0, 5'd3, 5'd3, 64'd0, 64'd0, 64'd0, 64'd0, 5'd8, 1'b0);
      tick();
      n_checks++; if (alu_a !== 64'd30 || alu_b !== 64'd30)
         $display("FAIL raw_forward got=%0d/%0d exp=30/30", alu_a, alu_b); else n_pass++;
      set_instr(8'h0, 1'b1, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0, 64'd10, 64'd20, 5'd0, 1'b1);
      tick();
      set_instr(8'h0, 1'b0, 1'b0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd8, 1'b0);
      tick();
      n_checks++; if (alu_a !== 64'd0 || alu_b !== 64'd0)
         $display("FAIL raw_x0_no_forward got=%0d/%0d exp=0/0", alu_a, alu_b); else n_pass++;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      set_instr(8'h7, 1'b1, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0, 64'd111, 64'd222, 5'd7, 1'b1);
      tick();
      out_ready = 1'b0;
      set_instr(8'h9, 1'b1, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0, 64'd333, 64'd444, 5'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%0d exp=0", i, in_ready); else n_pass++;
         tick();
         n_checks++; if (out_valid !== 1'b1 || alu_a !== 64'd111 || alu_b !== 64'd222 || alu_mode !== 8'h7 || out_rd !== 5'd7)
            $display("FAIL bp_hold cyc=%0d got=%0d/%0d/%0d exp=1/111/222", i, out_valid, alu_a, alu_b); else n_pass++;
      end
      out_ready = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%0d exp=1", in_ready); else n_pass++;
      tick();
      n_checks++; if (alu_a !== 64'd333 || alu_b !== 64'd444 || alu_mode !== 8'h9)
         $display("FAIL bp_next_load got=%0d/%0d exp=333/444", alu_a, alu_b); else n_pass++;
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      set_instr(8'h1, 1'b1, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0, 64'h55, 64'h66, 5'd5, 1'b1);
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      tick();
      flush = 1'b1;
      set_instr(8'h2, 1'b1, 1'b1, 5'd0, 5'd0, 64'd0, 64'd0, 64'h99, 64'h98, 5'd1, 1'b1);
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0d exp=0", in_ready); else n_pass++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%0d exp=0", out_valid); else n_pass++;
      n_checks++; if (alu_a !== 64'h55) $display("FAIL flush_no_capture got=%h exp=55", alu_a); else n_pass++;
`ifdef YSYX_22050612_IDEX_PERF_EN
      n_checks++; if (perf_stall_cnt !== 32'(m_stall))
         $display("FAIL perf_stall got=%0d exp=%0d", perf_stall_cnt, m_stall); else n_pass++;
`endif
   endtask

   task automatic test_random();
      logic [152:0] got, exp;
      for (int i = 0; i < 400; i++) begin
         flush       = ($urandom_range(0, 7) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         set_instr(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom_range(0, 3)), 1'($urandom));
         in_valid    = ($urandom_range(0, 3) != 0);
         #1;
         n_checks++; if (in_ready !== exp_ready())
            $display("FAIL rand_in_ready cyc=%0d got=%0d exp=%0d", i, in_ready, exp_ready()); else n_pass++;
         tick();
         got = {out_valid, alu_mode, alu_a, alu_b, out_rd, out_rd_wen};
         exp = {m_valid, m_mode, m_a, m_b, m_rd, m_wen};
         n_checks++; if (got !== exp) $display("FAIL rand_outputs cyc=%0d got=%h exp=%h", i, got, exp); else n_pass++;
      end
`ifdef YSYX_22050612_IDEX_PERF_EN
      n_checks++; if (perf_stall_cnt !== 32'(m_stall) || perf_fwd_cnt !== 32'(m_fwdc))
         $display("FAIL rand_perf got=%0d/%0d exp=%0d/%0d", perf_stall_cnt, perf_fwd_cnt, m_stall, m_fwdc); else n_pass++;
`endif
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      m_valid = 1'b0; m_mode = '0; m_a = '0; m_b = '0; m_rd = '0; m_wen = 1'b0;
`ifdef YSYX_22050612_IDEX_PERF_EN
      m_stall = 0; m_fwdc = 0;
`endif
      test_reset();
      test_basic_accept();
      test_operand_select();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
